// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller: round-robin N-approach signal controller with sensor extension, pedestrian walk and reprogrammable intervals
// Ports: clk system clock; rst_n async active-low reset; sensor vehicle present per approach;
//        walk_request pedestrian button; reprogram/selector/time_value interval write port (rising edge on reprogram);
//        green/yellow/red lamp drives per approach; walk pedestrian lamp; phase/state current position;
//        tick one-cycle 1 Hz pulse; expired one-cycle interval-end pulse.
module traffic_phase_controller #(
   parameter int NUM_PHASES = 2,
   parameter int TIME_W     = 4,
   parameter int CLK_DIV    = 100000,
   parameter int GREEN_DEF  = 6,
   parameter int EXT_DEF    = 3,
   parameter int YELLOW_DEF = 2,
   parameter int WALK_DEF   = 3,
   localparam int SEL_W = $clog2(NUM_PHASES + 3),
   localparam int PH_W  = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_PHASES-1:0] sensor,
   input  logic                  walk_request,
   input  logic                  reprogram,
   input  logic [SEL_W-1:0]      selector,
   input  logic [TIME_W-1:0]     time_value,
   output logic [NUM_PHASES-1:0] green,
   output logic [NUM_PHASES-1:0] yellow,
   output logic [NUM_PHASES-1:0] red,
   output logic                  walk,
   output logic [PH_W-1:0]       phase,
   output logic [2:0]            state,
   output logic                  tick,
   output logic                  expired
);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PH_W-1:0]  LAST_PH  = PH_W'(NUM_PHASES - 1);
   localparam logic [SEL_W-1:0] SEL_EXT  = SEL_W'(NUM_PHASES);
   localparam logic [SEL_W-1:0] SEL_YEL  = SEL_W'(NUM_PHASES + 1);
   localparam logic [SEL_W-1:0] SEL_WALK = SEL_W'(NUM_PHASES + 2);
   typedef enum logic [2:0] {S_GREEN = 3'd0, S_EXT = 3'd1, S_YELLOW = 3'd2, S_WALK = 3'd3} state_t;
   state_t                  st, st_nx;
   logic [PH_W-1:0]         ph, ph_nx;
   logic [TIME_W-1:0]       green_r [NUM_PHASES];
   logic [TIME_W-1:0]       ext_r, yellow_r, walk_r, timer, load_val;
   logic [DIV_W-1:0]        div;
   logic [NUM_PHASES-1:0]   lit;
   logic                    prog_q, force_g, enter, sens_l, walk_l;
   assign tick    = div == DIV_W'(CLK_DIV - 1);
   assign expired = tick && timer == TIME_W'(1);
   // a valid write always restarts the cycle, and wins over a coincident expiry
   assign force_g = reprogram && !prog_q && selector <= SEL_WALK && time_value != '0;
   assign enter   = force_g || expired;
   assign phase   = ph;
   assign state   = st;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         st <= S_GREEN;
         ph <= '0;
      end else begin
         st <= st_nx;
         ph <= ph_nx;
      end
   always_comb begin
      st_nx = st;
      ph_nx = ph;
      if (force_g) begin
         st_nx = S_GREEN;
         ph_nx = '0;
      end else if (expired) begin
         case (st)
            S_GREEN:  st_nx = (sens_l || sensor[ph]) ? S_EXT : S_YELLOW;
            S_EXT:    st_nx = S_YELLOW;
            S_YELLOW: begin
               st_nx = (ph == LAST_PH && (walk_l || walk_request)) ? S_WALK : S_GREEN;
               ph_nx = (ph == LAST_PH) ? '0 : ph + 1'b1;
            end
            default: begin
               st_nx = S_GREEN;
               ph_nx = '0;
            end
         endcase
      end
      // green[0] written by the forcing write takes effect in the very interval it starts
      load_val = (st_nx == S_EXT) ? ext_r :
                 (st_nx == S_YELLOW) ? yellow_r :
                 (st_nx == S_WALK) ? walk_r :
                 (force_g && selector == '0) ? time_value : green_r[ph_nx];
   end
   always_comb begin
      lit    = NUM_PHASES'(1) << ph;
      green  = (st == S_GREEN || st == S_EXT) ? lit : '0;
      yellow = (st == S_YELLOW) ? lit : '0;
      red    = ~(green | yellow);
      walk   = st == S_WALK;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         div      <= '0;
         timer    <= TIME_W'(GREEN_DEF);
         prog_q   <= 1'b0;
         sens_l   <= 1'b0;
         walk_l   <= 1'b0;
         ext_r    <= TIME_W'(EXT_DEF);
         yellow_r <= TIME_W'(YELLOW_DEF);
         walk_r   <= TIME_W'(WALK_DEF);
         for (int i = 0; i < NUM_PHASES; i++) green_r[i] <= TIME_W'(GREEN_DEF);
      end else begin
         prog_q <= reprogram;
         div    <= (enter || tick) ? '0 : div + 1'b1;
         timer  <= enter ? load_val : tick ? timer - 1'b1 : timer;
         sens_l <= !enter && (sens_l || (st == S_GREEN && sensor[ph]));
         walk_l <= !(force_g || (expired && st == S_WALK)) && (walk_l || (st != S_WALK && walk_request));
         if (force_g) begin
            if (selector == SEL_EXT) ext_r <= time_value;
            if (selector == SEL_YEL) yellow_r <= time_value;
            if (selector == SEL_WALK) walk_r <= time_value;
            for (int i = 0; i < NUM_PHASES; i++)
               if (selector == SEL_W'(i)) green_r[i] <= time_value;
         end
      end
endmodule

// File: doc/traffic_phase_controller.md
# traffic_phase_controller

- Parametrised multi-approach traffic-signal controller: N approaches, served round-robin.
- Each approach gets a programmable base green, an optional one-shot sensor extension and a yellow; an optional pedestrian walk interval runs at the end of each round.
- Contains its own 1 Hz tick divider, one-second-resolution interval timer and run-time reprogramming port.
- Sits between the board clock and the lamp/LED drivers, replacing the fixed two-road controller.

## Interface

Parameters:
- NUM_PHASES, 2, number of approaches (2..4)
- TIME_W, 4, width of every interval register and the timer (seconds)
- CLK_DIV, 100000, clk cycles per 1 s tick (100 kHz clk)
- GREEN_DEF, 6, reset base green (s), all phases
- EXT_DEF, 3, reset extension (s)
- YELLOW_DEF, 2, reset yellow (s)
- WALK_DEF, 3, reset walk (s)
- Derived localparams: SEL_W = $clog2(NUM_PHASES+3); PH_W = max(1, $clog2(NUM_PHASES))

Ports:
- clk  in  1  system clock
- Reset  in  1  asynchronous, active-low reset
- Sensor  in  NUM_PHASES  vehicle present, one bit per approach
- WalkRequest  in  1  pedestrian button, level or pulse
- Reprogram  in  1  write strobe, rising-edge active
- Selector  in  SEL_W  register select: 0..N-1 green[i], N ext, N+1 yellow, N+2 walk
- Time_Value  in  TIME_W  value written on Reprogram
- Green / Yellow / Red  out  NUM_PHASES each  lamp drives, one bit per approach
- Walk  out  1  pedestrian walk lamp
- Phase  out  PH_W  current approach
- State  out  3  0 GREEN, 1 EXT, 2 YELLOW, 3 WALK
- Tick  out  1  one-cycle 1 Hz pulse
- Expired  out  1  one-cycle interval-end pulse

## Operation

- **Reset** (Reset=0): asynchronous.
  - Registers load their defaults; walk latch and sensor latch clear; divider and timer load.
  - State=GREEN, Phase=0.
  - Outputs during and after reset: Green=...001, Red=~Green, Yellow=0, Walk=0, Tick=0, Expired=0.
- **Lamps** (Moore, decoded from registered State/Phase):
  - GREEN/EXT: Green[Phase]=1.
  - YELLOW: Yellow[Phase]=1.
  - WALK: all Red, Walk=1.
  - Every non-lit approach shows Red.
- **Transitions**, taken on Expired:
  - GREEN(p): Sensor[p] is latched on any cycle it is high in GREEN(p). Latch set → EXT(p); else → YELLOW(p).
  - EXT(p) → YELLOW(p). Exactly one extension per green, regardless of Sensor.
  - YELLOW(p), p<N-1 → GREEN(p+1).
  - YELLOW(N-1) → WALK if walk latch set or WalkRequest high that cycle; else → GREEN(0).
  - WALK → GREEN(0). Walk latch clears.
- **Walk latch:** sets on WalkRequest=1 in any state except WALK. Requests made during WALK are dropped.
- **Sensor latch:** clears on every state change.
- **Reprogram:** synchronous rising-edge detect on Reprogram.
  - Selector ≤ N+2 and Time_Value≠0: write Time_Value to the selected register, then force GREEN(0). Forcing GREEN(0) reloads timer and divider and clears both latches.
  - Selector > N+2 or Time_Value=0: the write is ignored, with no restart.
  - Rising edge coincident with Expired: Reprogram wins.

## Timing

- **Divider:** counts 0..CLK_DIV-1; Tick=1 when count=CLK_DIV-1.
- **Timer:** loads on state entry with the interval for the new state. Decrements on Tick.
- **Expired** = Tick && timer==1, combinational.
- **State entry:** the state register, timer load and divider clear all happen on the Expired edge.
  - Every state therefore lasts exactly interval×CLK_DIV cycles.
  - New lamps are visible the cycle after Expired.
- A register written mid-interval takes effect at the next entry of the affected state. Reprogram forces this immediately for green[0].
- Interval arithmetic is unsigned TIME_W; maximum interval is 2^TIME_W−1 s.

## Test plan

All scenarios run with NUM_PHASES=3 and CLK_DIV=4.

1. **Free run.** Reset pulse, no inputs.
   - Each approach: Green 24 cycles, then Yellow 8 cycles.
   - Sequence Phase 0→1→2→0; full round 96 cycles.
   - Tick every 4 cycles; Expired pulses exactly at each lamp change −1.
2. **Sensor extension.** Sensor[1] one-cycle pulse during GREEN(1).
   - Green[1] lasts 36 cycles, with State=1 for the final 12.
   - Holding Sensor[1] high throughout still gives only 36 cycles.
   - Sensor[0] pulsed during GREEN(1) has no effect.
3. **Walk.** WalkRequest 1-cycle pulse during GREEN(0).
   - After YELLOW(2): 12 cycles of Walk=1 with Red=111, then GREEN(0).
   - Next round has no WALK.
   - A second pulse during WALK is dropped.
4. **Reprogram.** Selector=1, Time_Value=2, Reprogram 0→1 during YELLOW(2).
   - Next cycle: GREEN(0), with the timer restarted for 24 cycles.
   - Green[1] then lasts 8 cycles.
   - Time_Value=0 or Selector=7 leaves all registers and the current state unchanged.
5. **Async reset.** Reset→0 mid-YELLOW(1).
   - Outputs take reset values without waiting for a clk edge.
   - After release: GREEN(0) with default 24-cycle green, even if green[0] was reprogrammed before.
6. **Simultaneous events.** WalkRequest rises in the same cycle YELLOW(2) expires.
   - Next state is WALK.
   - A Reprogram edge in the cycle WALK expires forces GREEN(0) and applies the write.
